riscv_fetch_unit: RTL
=====================

Name: riscv_fetch_unit

Overview:
Instruction fetch stage for the single-cycle RISC-V test core. Captures the packed 1024-bit instruction image driven on load_ins into a local 32-word instruction memory. Walks it from RESET_PC and presents pc and inst_out to decode with a valid/ready handshake. Supports branch/jump redirect, halts on running off the end of the image, and flags misaligned redirect targets.

Parameters:
IMEM_DEPTH, 32, number of 32-bit instruction words (image width = IMEM_DEPTH*32; power of two).
RESET_PC, 32'h0000_0000, byte address of first fetch after load (word aligned).

Ports:
clk  input  1  core clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset
load_en  input  1  pulse: capture load_ins and restart fetch
load_ins  input  IMEM_DEPTH*32  packed image, word i = load_ins[32*i +: 32]
redirect_valid  input  1  branch/jump taken, redirect fetch
redirect_pc  input  32  redirect target byte address
out_ready  input  1  decode accepts current instruction
pc  output  32  byte address of inst_out
inst_out  output  32  fetched instruction word
inst_valid  output  1  pc/inst_out valid
halted  output  1  fetch pointer left the image
fetch_err  output  1  sticky misaligned-redirect error
inst_count  output  32  accepted instruction count

Behaviour:
- Reset (reset=0, async): state=IDLE, pc=RESET_PC, inst_out=0, inst_valid=0, halted=0, fetch_err=0, inst_count=0, imem cleared to 0, internal fetch pointer fpc=RESET_PC.
- States: IDLE, RUN, HALT, ERR.
- load_en, any state, highest priority:
  - imem<=load_ins and fpc<=RESET_PC.
  - inst_valid<=0, halted<=0, fetch_err<=0, inst_count<=0.
  - state<=RUN.
- Issue rule (RUN, no redirect, no load_en): issue when !inst_valid || out_ready.
  - In range (fpc[31:2] < IMEM_DEPTH): pc<=fpc, inst_out<=imem[fpc[31:2]], inst_valid<=1, fpc<=fpc+4.
  - Out of range: inst_valid<=0, halted<=1, state<=HALT.
- Latency: load_en sampled at edge N; inst_valid=1 with pc=RESET_PC after edge N+1.
- Stall: inst_valid && !out_ready holds pc, inst_out, inst_valid and fpc unchanged.
- inst_count increments by 1 on every edge with inst_valid && out_ready (including the accepting edge of a redirect). Wraps modulo 2^32.
- Redirect (redirect_valid=1, state RUN or HALT, no load_en):
  - Output is flushed: inst_valid<=0 regardless of out_ready.
  - redirect_pc[1:0]==0: fpc<=redirect_pc, halted<=0, state<=RUN. Next issue follows the normal rule; an out-of-range target halts on the following edge.
  - redirect_pc[1:0]!=0: fetch_err<=1, state<=ERR, fpc unchanged.
- IDLE: ignores redirect_valid and out_ready; outputs hold reset values until load_en.
- ERR: inst_valid=0, fetch_err=1, redirect ignored. Exit only via load_en or reset.
- HALT: inst_valid=0, halted=1. Exit via aligned redirect, load_en or reset.
- Simultaneous load_en and redirect_valid: load_en wins, redirect dropped.
- Reset asserted mid-stream: all outputs return to reset values immediately; the image is lost and must be reloaded.
- fpc arithmetic: 32-bit wrap on +4; the range check uses the full fpc[31:2].

Test Plan:
1. Reset, load image word i = 32'h0000_0013 + (i<<7), out_ready=1 -> pc 0,4,8,…,124 on consecutive cycles with matching words. At 128: inst_valid=0, halted=1. inst_count=32.
2. Stream with out_ready toggling 1,0,0,1 -> pc/inst_out held stable while stalled. No word skipped or duplicated; inst_count equals accepted handshakes only.
3. Redirect_pc=32'h40 while pc=8 and inst_valid=1 -> inst_valid=0 next cycle, then pc=32'h40, inst_out=word 16. No word 3 issued.
4. Redirect_pc=32'h42 -> fetch_err=1, state ERR, inst_valid=0; further redirects ignored. load_en -> fetch_err=0, pc=RESET_PC re-issued after 2 edges.
5. From HALT, redirect_pc=32'h10 -> halted=0, pc=32'h10 issued. Redirect_pc=32'h200 -> halted=1 again after 2 edges.
6. load_en and redirect_valid in the same cycle -> restart at RESET_PC, redirect ignored. reset=0 mid-stream -> outputs zero/RESET_PC asynchronously, before the next clock edge.

Source files
------------

// File: rtl/riscv_fetch_unit.sv
// Instruction fetch: captures a packed image into local imem and streams pc/inst_out to decode.
// First word valid one edge after load_en; a stall (inst_valid && !out_ready) freezes pc, inst_out and the fetch pointer.
module riscv_fetch_unit #(
  parameter int unsigned IMEM_DEPTH = 32,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_en,
  input  logic [IMEM_DEPTH*32-1:0] load_ins,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  input  logic                     out_ready,
  output logic [31:0]              pc,
  output logic [31:0]              inst_out,
  output logic                     inst_valid,
  output logic                     halted,
  output logic                     fetch_err,
  output logic [31:0]              inst_count
);

  localparam int unsigned IDX_W       = $clog2(IMEM_DEPTH);
  localparam logic [29:0] DEPTH_WORDS = 30'(IMEM_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [31:0] fpc;
  logic [31:0] fpc_nxt;
  logic [31:0] pc_nxt;
  logic [31:0] inst_nxt;
  logic [31:0] count_nxt;
  logic        valid_nxt;
  logic        halted_nxt;
  logic        err_nxt;

  logic [31:0] imem [IMEM_DEPTH];

  logic        accept;
  logic        fetch_in_range;
  logic        redirect_live;
  logic        redirect_aligned;
  logic        issue;
  logic [31:0] fetch_word;

  assign accept           = inst_valid && out_ready;
  // Range check covers the full word address so wrapped or far pointers halt instead of aliasing.
  assign fetch_in_range   = fpc[31:2] < DEPTH_WORDS;
  assign redirect_live    = redirect_valid && (state == S_RUN || state == S_HALT);
  assign redirect_aligned = redirect_pc[1:0] == 2'b00;
  assign issue            = (state == S_RUN) && !redirect_valid && (!inst_valid || out_ready);
  assign fetch_word       = imem[fpc[IDX_W+1:2]];

  always_comb begin
    state_nxt  = state;
    fpc_nxt    = fpc;
    pc_nxt     = pc;
    inst_nxt   = inst_out;
    valid_nxt  = inst_valid;
    halted_nxt = halted;
    err_nxt    = fetch_err;
    count_nxt  = inst_count + 32'(accept);

    if (load_en) begin
      state_nxt  = S_RUN;
      fpc_nxt    = RESET_PC;
      valid_nxt  = 1'b0;
      halted_nxt = 1'b0;
      err_nxt    = 1'b0;
      count_nxt  = 32'd0;
    end else if (redirect_live) begin
      // A taken branch always flushes whatever decode was looking at.
      valid_nxt = 1'b0;
      if (redirect_aligned) begin
        fpc_nxt    = redirect_pc;
        halted_nxt = 1'b0;
        state_nxt  = S_RUN;
      end else begin
        err_nxt   = 1'b1;
        state_nxt = S_ERR;
      end
    end else if (issue) begin
      if (fetch_in_range) begin
        pc_nxt    = fpc;
        inst_nxt  = fetch_word;
        valid_nxt = 1'b1;
        fpc_nxt   = fpc + 32'd4;
      end else begin
        valid_nxt  = 1'b0;
        halted_nxt = 1'b1;
        state_nxt  = S_HALT;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      fpc        <= RESET_PC;
      pc         <= RESET_PC;
      inst_out   <= 32'd0;
      inst_valid <= 1'b0;
      halted     <= 1'b0;
      fetch_err  <= 1'b0;
      inst_count <= 32'd0;
    end else begin
      state      <= state_nxt;
      fpc        <= fpc_nxt;
      pc         <= pc_nxt;
      inst_out   <= inst_nxt;
      inst_valid <= valid_nxt;
      halted     <= halted_nxt;
      fetch_err  <= err_nxt;
      inst_count <= count_nxt;
    end
  end

  // The image does not survive reset; software must reload it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < IMEM_DEPTH; i++) imem[i] <= 32'd0;
    end else if (load_en) begin
      for (int i = 0; i < IMEM_DEPTH; i++) imem[i] <= load_ins[32*i +: 32];
    end
  end

endmodule
